fft_pingpong_ram: RTL

Double-buffered complex sample memory for the streaming FFT. It holds two banks of 2**M complex words. While the butterfly datapath works in place on one bank, the I/O side loads the next frame into the other bank and unloads the previous one. A done/done handshake exchanges the banks without losing a cycle. It replaces the single combinational-read two-port RAM: reads are registered, and bank ownership is tracked in hardware.

---
 rtl/fft_mem_pkg.sv | 17 +
 rtl/fft_mem_bank.sv | 36 +++
 rtl/fft_pingpong_ram.sv | 111 +++++++++++
 3 files changed

// File: rtl/fft_mem_pkg.sv
// rtl/fft_mem_pkg.sv - shared types for the ping-pong FFT sample memory
package fft_mem_pkg;

  localparam int CPLX_WIDTH = 16;

  typedef struct packed {
    logic [CPLX_WIDTH-1:0] re;
    logic [CPLX_WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_IO  = 2'd1,
    WAIT_FFT = 2'd2
  } hs_state_e;

endpackage

// File: rtl/fft_mem_bank.sv
// rtl/fft_mem_bank.sv - one bank: two write ports (B wins), two registered read ports
module fft_mem_bank #(
  parameter int WIDTH = 16,
  parameter int M     = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               we_a,
  input  logic               we_b,
  input  logic [M-1:0]       adr_a,
  input  logic [M-1:0]       adr_b,
  input  logic [2*WIDTH-1:0] wd_a,
  input  logic [2*WIDTH-1:0] wd_b,
  output logic [2*WIDTH-1:0] rd_a,
  output logic [2*WIDTH-1:0] rd_b
);

  logic [2*WIDTH-1:0] mem [2**M];

  // Port B is written last so it overrides port A on an address clash.
  always_ff @(posedge clk) begin
    if (we_a) mem[adr_a] <= wd_a;
    if (we_b) mem[adr_b] <= wd_b;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_a <= '0;
      rd_b <= '0;
    end else begin
      rd_a <= mem[adr_a];
      rd_b <= mem[adr_b];
    end
  end

endmodule

// File: rtl/fft_pingpong_ram.sv
// rtl/fft_pingpong_ram.sv - double-buffered FFT sample memory with done/done bank swap
module fft_pingpong_ram
  import fft_mem_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int M     = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               fft_we,
  input  logic [M-1:0]       fft_adra,
  input  logic [M-1:0]       fft_adrb,
  input  logic [2*WIDTH-1:0] fft_wda,
  input  logic [2*WIDTH-1:0] fft_wdb,
  output logic [2*WIDTH-1:0] fft_rda,
  output logic [2*WIDTH-1:0] fft_rdb,
  input  logic               io_we,
  input  logic [M-1:0]       io_adr,
  input  logic [2*WIDTH-1:0] io_wd,
  output logic [2*WIDTH-1:0] io_rd,
  input  logic               fft_done,
  input  logic               io_done,
  output logic               fft_bank,
  output logic               swap,
  output logic               collision
);

  localparam int DW = 2 * WIDTH;

  hs_state_e     state;
  logic          rd_sel;
  logic [1:0]    own;
  logic [1:0]    we_a;
  logic [1:0]    we_b;
  logic [M-1:0]  adr_a [2];
  logic [M-1:0]  adr_b [2];
  logic [DW-1:0] wd_a  [2];
  logic [DW-1:0] wd_b  [2];
  logic [DW-1:0] rd_a  [2];
  logic [DW-1:0] rd_b  [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign own[b]   = (fft_bank == 1'(b));
    assign we_a[b]  = own[b] ? fft_we   : io_we;
    assign adr_a[b] = own[b] ? fft_adra : io_adr;
    assign wd_a[b]  = own[b] ? fft_wda  : io_wd;
    assign we_b[b]  = own[b] & fft_we;
    assign adr_b[b] = fft_adrb;
    assign wd_b[b]  = fft_wdb;

    fft_mem_bank #(.WIDTH(WIDTH), .M(M)) u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .we_a    (we_a[b]),
      .we_b    (we_b[b]),
      .adr_a   (adr_a[b]),
      .adr_b   (adr_b[b]),
      .wd_a    (wd_a[b]),
      .wd_b    (wd_b[b]),
      .rd_a    (rd_a[b]),
      .rd_b    (rd_b[b])
    );
  end

  // rd_sel is the mapping the read data was fetched with, so the swap cycle still sees old-bank data.
  assign fft_rda = rd_a[rd_sel];
  assign fft_rdb = rd_b[rd_sel];
  assign io_rd   = rd_a[~rd_sel];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      fft_bank  <= 1'b0;
      swap      <= 1'b0;
      collision <= 1'b0;
      rd_sel    <= 1'b0;
    end else begin
      swap      <= 1'b0;
      collision <= fft_we && (fft_adra == fft_adrb);
      rd_sel    <= fft_bank;
      case (state)
        RUN: begin
          if (fft_done && io_done) begin
            fft_bank <= ~fft_bank;
            swap     <= 1'b1;
          end else if (fft_done) begin
            state <= WAIT_IO;
          end else if (io_done) begin
            state <= WAIT_FFT;
          end
        end
        WAIT_IO: begin
          if (io_done) begin
            fft_bank <= ~fft_bank;
            swap     <= 1'b1;
            state    <= RUN;
          end
        end
        WAIT_FFT: begin
          if (fft_done) begin
            fft_bank <= ~fft_bank;
            swap     <= 1'b1;
            state    <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
